mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, meaning: max cycles the block waits in S_WAIT for mem_done before it abandons the access.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 req_enable  input  3  one-cycle request pulse per requester; bit i = requester i (0 = ring buffer consumer, 1 = host writer, 2 = interpreter).
REQ-005 req_readWrite  input  3  per requester; 1 = read, 0 = write.
REQ-006 req_address  input  45  requester i address at bits [15i+14:15i].
REQ-007 req_dataWrite  input  96  requester i write data at bits [32i+31:32i].
REQ-008 req_done  output  3  one-cycle completion pulse to the granted requester.
REQ-009 req_timeout  output  3  one-cycle abandon pulse to the granted requester.
REQ-010 req_dataOut  output  32  read data; shared by all requesters, valid when the matching req_done bit is high.
REQ-011 mem_enable  output  1  one-cycle access pulse to memory.
REQ-012 mem_readWrite  output  1  1 = read, 0 = write.
REQ-013 mem_address  output  15  memory word address.
REQ-014 mem_DataWrite  output  32  memory write data.
REQ-015 mem_DataOut  input  32  memory read data, valid with mem_done.
REQ-016 mem_done  input  1  memory completion pulse.
REQ-017 busy  output  1  high while an access is outstanding (S_WAIT).
REQ-018 grant_id  output  2  index of the last or current granted requester.

Function
REQ-019 Each requester SHALL own a pending flag plus latched readWrite/address/dataWrite; a req_enable bit at a clock edge SHALL set its flag and capture its payload.
REQ-020 A req_enable while that requester's flag is set SHALL be ignored, leaving payload unchanged; the exception is the completion cycle (REQ-025).
REQ-021 The FSM SHALL have exactly two states: S_IDLE and S_WAIT.
REQ-022 In S_IDLE with any flag set, the block SHALL grant round-robin, searching from last_grant+1 modulo 3.
REQ-022 (cont.) On grant it SHALL set grant_id, drive mem_enable=1 with the latched payload for one cycle, clear the timeout counter and enter S_WAIT.
REQ-023 Latency: a pulse at edge N to an idle block with no other pending requester SHALL produce mem_enable high in the cycle after edge N+1.
REQ-024 In S_WAIT, mem_enable SHALL be 0, and mem_done SHALL be sampled from the first cycle after the mem_enable pulse.
REQ-025 On mem_done in S_WAIT, the block SHALL, at the same edge:
- register req_dataOut <= mem_DataOut;
- pulse req_done[grant] for one cycle;
- clear the grant's flag;
- set last_grant <= grant;
- return to S_IDLE.
A req_enable from the same requester at that edge SHALL re-set its flag (set wins).
REQ-026 If TIMEOUT_CYCLES cycles elapse in S_WAIT without mem_done, the block SHALL pulse req_timeout[grant], clear the flag, update last_grant and return to S_IDLE; req_dataOut SHALL be unchanged.
REQ-027 mem_done received in S_IDLE SHALL be ignored.
REQ-028 At most one memory access SHALL be outstanding at any time, and req_done/req_timeout SHALL be one-hot or zero.
REQ-029 For write grants, req_dataOut SHALL still update from mem_DataOut; requesters ignore it.
REQ-030 mem_address, mem_DataWrite and mem_readWrite SHALL hold their values between grants.

Reset
REQ-031 With rst low at a clock edge, the block SHALL set:
- state S_IDLE; all pending flags 0;
- last_grant=2, so requester 0 wins first; grant_id=0;
- mem_enable=0, mem_readWrite=1, mem_address=0, mem_DataWrite=0;
- req_done=0, req_timeout=0, req_dataOut=0, busy=0; timeout counter 0.
REQ-032 Reset asserted in S_WAIT SHALL abandon the access without any req_done or req_timeout pulse, and a late mem_done after reset SHALL be ignored.

Verification
REQ-033 Requester 0 pulses a read of addr 0x0002; memory returns 0x00000005 two cycles after mem_enable -> one mem_enable pulse with mem_address=0x0002, mem_readWrite=1; req_done=3'b001; req_dataOut=5.
REQ-034 All three requesters pulse in the same cycle after reset -> grants in order 0,1,2, each with its own address; exactly three mem_enable pulses.
REQ-035 Requester 1 pulses a write of 0x3 to addr 0x0001; mem_done is never asserted -> req_timeout=3'b010 after 16 cycles in S_WAIT; busy drops; the next pending request is served.
REQ-036 Requester 2 re-pulses with addr 0x0007 while pending with addr 0x0004 -> the memory sees only 0x0004.
REQ-036 (cont.) A re-pulse with 0x0008 on its req_done edge -> second access to 0x0008.
REQ-037 rst low for one cycle during S_WAIT, then mem_done arrives -> no req_done; all outputs at reset values; no new mem_enable until a fresh request.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving three requesters shared access to a single-port memory.
// Latency: pulse at edge N -> flag set; grant at edge N+1 -> mem_enable high the following cycle.
// Backpressure: one request per requester held pending; re-pulses while pending are dropped.
module mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req_enable,
   input  logic [2:0]  req_readWrite,
   input  logic [44:0] req_address,
   input  logic [95:0] req_dataWrite,
   output logic [2:0]  req_done,
   output logic [2:0]  req_timeout,
   output logic [31:0] req_dataOut,
   output logic        mem_enable,
   output logic        mem_readWrite,
   output logic [14:0] mem_address,
   output logic [31:0] mem_DataWrite,
   input  logic [31:0] mem_DataOut,
   input  logic        mem_done,
   output logic        busy,
   output logic [1:0]  grant_id
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t         state, state_nxt;
   logic [2:0]     pend;
   logic [2:0]     lat_rw;
   logic [14:0]    lat_addr [3];
   logic [31:0]    lat_dat  [3];
   logic [1:0]     last_grant;
   logic [CW-1:0]  cnt;
   logic [1:0]     c0, c1, c2, pick;
   logic           do_grant, do_done, do_tmo;
   logic [2:0]     fin_mask;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   // Round-robin pick starting after the last granted requester
   always_comb begin
      c0   = inc3(last_grant);
      c1   = inc3(c0);
      c2   = inc3(c1);
      pick = c0;
      if (pend[c0])      pick = c0;
      else if (pend[c1]) pick = c1;
      else if (pend[c2]) pick = c2;
   end

   // Next state and per-cycle events; mem_done during the enable pulse cycle is not yet valid
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_done   = 1'b0;
      do_tmo    = 1'b0;
      case (state)
         S_IDLE: begin
            if (|pend) begin
               do_grant  = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_done && !mem_enable) begin
               do_done   = 1'b1;
               state_nxt = S_IDLE;
            end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               do_tmo    = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      fin_mask = (do_done || do_tmo) ? (3'b001 << grant_id) : 3'b000;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Pending flags and latched payloads; a pulse on the finishing edge re-arms the flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend   <= 3'b000;
         lat_rw <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            lat_addr[i] <= 15'd0;
            lat_dat[i]  <= 32'd0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (req_enable[i] && (!pend[i] || fin_mask[i])) begin
               pend[i]     <= 1'b1;
               lat_rw[i]   <= req_readWrite[i];
               lat_addr[i] <= req_address[15*i +: 15];
               lat_dat[i]  <= req_dataWrite[32*i +: 32];
            end else if (fin_mask[i]) begin
               pend[i] <= 1'b0;
            end
         end
      end
   end

   // Memory-side outputs, completion pulses, grant bookkeeping and timeout counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_enable    <= 1'b0;
         mem_readWrite <= 1'b1;
         mem_address   <= 15'd0;
         mem_DataWrite <= 32'd0;
         req_done      <= 3'b000;
         req_timeout   <= 3'b000;
         req_dataOut   <= 32'd0;
         grant_id      <= 2'd0;
         last_grant    <= 2'd2;
         cnt           <= '0;
      end else begin
         mem_enable  <= 1'b0;
         req_done    <= 3'b000;
         req_timeout <= 3'b000;
         if (do_grant) begin
            grant_id      <= pick;
            mem_enable    <= 1'b1;
            mem_readWrite <= lat_rw[pick];
            mem_address   <= lat_addr[pick];
            mem_DataWrite <= lat_dat[pick];
            cnt           <= '0;
         end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
         end
         if (do_done) begin
            req_dataOut <= mem_DataOut;
            req_done    <= fin_mask;
            last_grant  <= grant_id;
         end
         if (do_tmo) begin
            req_timeout <= fin_mask;
            last_grant  <= grant_id;
         end
      end
   end

   assign busy = (state == S_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, three-way round robin, timeout,
// pending re-pulse handling and reset during an outstanding access.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_enable;
   logic [2:0]  req_readWrite;
   logic [44:0] req_address;
   logic [95:0] req_dataWrite;
   logic [2:0]  req_done;
   logic [2:0]  req_timeout;
   logic [31:0] req_dataOut;
   logic        mem_enable;
   logic        mem_readWrite;
   logic [14:0] mem_address;
   logic [31:0] mem_DataWrite;
   logic [31:0] mem_DataOut;
   logic        mem_done;
   logic        busy;
   logic [1:0]  grant_id;

   int checks = 0;
   int errors = 0;
   int en_cnt = 0;
   int base;
   bit ok;

   mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_enable(req_enable), .req_readWrite(req_readWrite),
      .req_address(req_address), .req_dataWrite(req_dataWrite),
      .req_done(req_done), .req_timeout(req_timeout), .req_dataOut(req_dataOut),
      .mem_enable(mem_enable), .mem_readWrite(mem_readWrite),
      .mem_address(mem_address), .mem_DataWrite(mem_DataWrite),
      .mem_DataOut(mem_DataOut), .mem_done(mem_done),
      .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   // Count memory access pulses mid-cycle
   always @(negedge clk) if (mem_enable === 1'b1) en_cnt++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_en(output bit found);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem_enable === 1'b1) begin
            found = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic pulse(input int id, input logic rw, input logic [14:0] addr, input logic [31:0] dat);
      req_enable              = 3'b000;
      req_enable[id]          = 1'b1;
      req_readWrite[id]       = rw;
      req_address[15*id +: 15] = addr;
      req_dataWrite[32*id +: 32] = dat;
   endtask

   // Wait for a grant, check it, then complete it one cycle later
   task automatic serve(input string tag, input logic [1:0] id, input logic [14:0] addr, input logic [31:0] dat);
      bit f;
      wait_en(f);
      check({tag, "_en_seen"}, {31'd0, f}, 32'd1);
      check({tag, "_grant"}, {30'd0, grant_id}, {30'd0, id});
      check({tag, "_addr"}, {17'd0, mem_address}, {17'd0, addr});
      step();
      mem_done    = 1'b1;
      mem_DataOut = dat;
      step();
      mem_done = 1'b0;
      check({tag, "_done"}, {29'd0, req_done}, {29'd0, 3'b001 << id});
      check({tag, "_dout"}, req_dataOut, dat);
   endtask

   initial begin
      rst = 1'b0; req_enable = '0; req_readWrite = '0; req_address = '0;
      req_dataWrite = '0; mem_DataOut = '0; mem_done = 1'b0;
      step(); step();
      check("rst_en",    {31'd0, mem_enable}, 32'd0);
      check("rst_rw",    {31'd0, mem_readWrite}, 32'd1);
      check("rst_addr",  {17'd0, mem_address}, 32'd0);
      check("rst_wdat",  mem_DataWrite, 32'd0);
      check("rst_done",  {29'd0, req_done}, 32'd0);
      check("rst_tmo",   {29'd0, req_timeout}, 32'd0);
      check("rst_dout",  req_dataOut, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_grant", {30'd0, grant_id}, 32'd0);
      rst = 1'b1;
      step();

      // Single read from requester 0, memory answers two cycles after the enable
      pulse(0, 1'b1, 15'h0002, 32'd0);
      step();
      req_enable = '0;
      check("t1_no_en_yet", {31'd0, mem_enable}, 32'd0);
      step();
      check("t1_en",   {31'd0, mem_enable}, 32'd1);
      check("t1_addr", {17'd0, mem_address}, 32'h2);
      check("t1_rw",   {31'd0, mem_readWrite}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      step();
      check("t1_en_low", {31'd0, mem_enable}, 32'd0);
      step();
      mem_done = 1'b1; mem_DataOut = 32'h5;
      step();
      mem_done = 1'b0;
      check("t1_done", {29'd0, req_done}, 32'b001);
      check("t1_dout", req_dataOut, 32'h5);
      check("t1_idle", {31'd0, busy}, 32'd0);
      step();
      check("t1_done_pulse", {29'd0, req_done}, 32'd0);

      // Three simultaneous requests after reset are served 0,1,2
      rst = 1'b0; step(); rst = 1'b1;
      req_enable = 3'b111; req_readWrite = 3'b111;
      req_address = {15'h12, 15'h11, 15'h10};
      step();
      req_enable = '0;
      base = en_cnt;
      serve("t2_r0", 2'd0, 15'h10, 32'h100);
      serve("t2_r1", 2'd1, 15'h11, 32'h101);
      serve("t2_r2", 2'd2, 15'h12, 32'h102);
      step();
      check("t2_en_count", en_cnt - base, 32'd3);

      // Write from requester 1 that never completes; requester 2 queues behind it
      pulse(1, 1'b0, 15'h0001, 32'h3);
      step();
      req_enable = '0;
      wait_en(ok);
      check("t3_en_seen", {31'd0, ok}, 32'd1);
      check("t3_wdat", mem_DataWrite, 32'h3);
      check("t3_rw",   {31'd0, mem_readWrite}, 32'd0);
      check("t3_addr", {17'd0, mem_address}, 32'h1);
      step();
      pulse(2, 1'b1, 15'h0020, 32'd0);
      step();
      req_enable = '0;
      for (int i = 0; i < 13; i++) step();
      check("t3_still_busy", {31'd0, busy}, 32'd1);
      check("t3_no_tmo_yet", {29'd0, req_timeout}, 32'd0);
      step();
      check("t3_tmo",  {29'd0, req_timeout}, 32'b010);
      check("t3_busy", {31'd0, busy}, 32'd0);
      check("t3_nodone", {29'd0, req_done}, 32'd0);
      check("t3_dout_kept", req_dataOut, 32'h102);
      serve("t3_next", 2'd2, 15'h20, 32'h55);
      step();

      // Re-pulse while pending is dropped; re-pulse on the done edge is kept
      base = en_cnt;
      pulse(2, 1'b1, 15'h0004, 32'd0);
      step();
      pulse(2, 1'b1, 15'h0007, 32'd0);
      step();
      req_enable = '0;
      check("t4_en",   {31'd0, mem_enable}, 32'd1);
      check("t4_addr", {17'd0, mem_address}, 32'h4);
      step();
      mem_done = 1'b1; mem_DataOut = 32'h44;
      pulse(2, 1'b1, 15'h0008, 32'd0);
      step();
      mem_done = 1'b0; req_enable = '0;
      check("t4_done", {29'd0, req_done}, 32'b100);
      serve("t4_second", 2'd2, 15'h8, 32'h88);
      step();
      check("t4_en_count", en_cnt - base, 32'd2);

      // Reset during an outstanding access, then a late mem_done
      pulse(0, 1'b1, 15'h0009, 32'd0);
      step();
      req_enable = '0;
      wait_en(ok);
      check("t5_en_seen", {31'd0, ok}, 32'd1);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      mem_done = 1'b1; mem_DataOut = 32'hAA;
      step();
      mem_done = 1'b0;
      base = en_cnt;
      check("t5_done",  {29'd0, req_done}, 32'd0);
      check("t5_tmo",   {29'd0, req_timeout}, 32'd0);
      check("t5_dout",  req_dataOut, 32'd0);
      check("t5_busy",  {31'd0, busy}, 32'd0);
      check("t5_grant", {30'd0, grant_id}, 32'd0);
      check("t5_addr",  {17'd0, mem_address}, 32'd0);
      check("t5_rw",    {31'd0, mem_readWrite}, 32'd1);
      check("t5_wdat",  mem_DataWrite, 32'd0);
      check("t5_en",    {31'd0, mem_enable}, 32'd0);
      for (int i = 0; i < 5; i++) step();
      check("t5_quiet", en_cnt - base, 32'd0);
      pulse(1, 1'b1, 15'h0033, 32'd0);
      step();
      req_enable = '0;
      serve("t5_fresh", 2'd1, 15'h33, 32'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
